// File: rtl/mem_arb_pkg.sv
// Shared constants for the MIO data-RAM port arbiter.
// Two-bit sequencer state encoding plus the master identifiers.
package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: remembers the last served master and
// favours the other one on a tie. Grant is combinational from the requests.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic m0_req,
  input  logic m1_req,
  input  logic update,
  input  logic update_id,
  output logic grant_valid,
  output logic grant_id
);

  logic last;

  // Resets to M1 so that master 0 wins the very first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= M1;
    end else if (update) begin
      last <= update_id;
    end
  end

  always_comb begin
    grant_valid = m0_req | m1_req;
    if (m0_req && m1_req) begin
      grant_id = ~last;
    end else if (m1_req) begin
      grant_id = M1;
    end else begin
      grant_id = M0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer sharing one data-RAM port
// between the CPU (master 0) and a second bus master (master 1).
//
//   state | meaning
//   IDLE  | waiting for a request; picks a master and latches its access
//   ISSUE | RAM pins driven for one cycle; ram_we high only for writes
//   WAIT  | read latency countdown; ram_dout captured when it hits 0
//   RESP  | ready pulse to the granted master; round-robin pointer updated
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  logic [1:0] state;
  logic [1:0] lat_cnt;
  logic       pick_valid;
  logic       pick_id;
  logic       rr_update;

  assign rr_update = (state == RESP);

  rr_pick2 u_pick (
    .clk         (clk),
    .rst_n       (RSTN),
    .m0_req      (m0_req),
    .m1_req      (m1_req),
    .update      (rr_update),
    .update_id   (grant_id),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      busy     <= 1'b0;
      grant_id <= M0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      ram_we   <= 1'b0;
      case (state)
        IDLE: begin
          // RAM pins are loaded on the grant edge so they are valid throughout ISSUE.
          if (pick_valid) begin
            grant_id <= pick_id;
            busy     <= 1'b1;
            state    <= ISSUE;
            if (pick_id == M1) begin
              ram_we   <= m1_we;
              ram_addr <= m1_addr;
              ram_din  <= m1_wdata;
            end else begin
              ram_we   <= m0_we;
              ram_addr <= m0_addr;
              ram_din  <= m0_wdata;
            end
          end
        end
        ISSUE: begin
          if (ram_we) begin
            m0_ready <= (grant_id == M0);
            m1_ready <= (grant_id == M1);
            state    <= RESP;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            if (grant_id == M1) begin
              m1_rdata <= ram_dout;
            end else begin
              m0_rdata <= ram_dout;
            end
            m0_ready <= (grant_id == M0);
            m1_ready <= (grant_id == M1);
            state    <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
